// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for the 8-input Mux8 result bus: grants one requester,
// runs valid/ready with the consumer on S, acks accepted beats, bounds burst length.
module mux8_rr_arbiter #(
    parameter int unsigned BEAT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] last,
    input  logic       out_ready,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       out_valid,
    output logic [7:0] ack,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] gnt_q, gnt_d;
    logic [7:0] cnt_q, cnt_d;

    logic [7:0] cand;
    logic [2:0] base;
    logic [3:0] pick;
    logic       g_req;
    logic       g_last;
    logic       accept;
    logic       at_limit;

    // Returns {found, index}; search starts at base+1 and wraps, base itself checked last.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] b);
        logic       found;
        logic [2:0] idx;
        logic [2:0] w;
        found = 1'b0;
        w     = '0;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = b + 3'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        return {found, w};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= 3'd7;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // One shared search: from ptr when idle, from the current owner (excluded) on hand-over.
    always_comb begin
        cand     = (state_q == GRANT) ? (req & ~gnt_q) : req;
        base     = (state_q == GRANT) ? sel_q : ptr_q;
        pick     = rr_pick(cand, base);
        g_req    = req[sel_q];
        g_last   = last[sel_q];
        at_limit = (({1'b0, cnt_q} + 9'd1) == 9'(BEAT_LIMIT));
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        out_valid = 1'b0;
        ack       = '0;
        busy      = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick[3]) begin
                    sel_d   = pick[2:0];
                    gnt_d   = 8'b1 << pick[2:0];
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                busy      = 1'b1;
                out_valid = g_req;
                accept    = g_req && out_ready;
                if (accept) begin
                    ack   = gnt_q;
                    cnt_d = cnt_q + 8'd1;
                end
                if (!g_req || (accept && (g_last || at_limit))) begin
                    ptr_d = sel_q;
                    cnt_d = '0;
                    if (pick[3]) begin
                        sel_d = pick[2:0];
                        gnt_d = 8'b1 << pick[2:0];
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel = sel_q;
    assign gnt = gnt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a cycle-level reference model.
module tb_mux8_rr_arbiter;

    localparam int unsigned BL = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] last;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       out_valid;
    logic [7:0] ack;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    mux8_rr_arbiter #(.BEAT_LIMIT(BL)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .sel       (sel),
        .gnt       (gnt),
        .out_valid (out_valid),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] rq;
        logic [7:0] ls;
        logic       rdy;
        logic [7:0] e_gnt;
        logic [2:0] e_sel;
        logic       e_v;
        logic [7:0] e_ack;
        logic       e_busy;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eg, input logic [2:0] es,
                           input logic ev, input logic [7:0] ea, input logic eb);
        chk({tag, ".gnt"}, gnt, eg);
        chk({tag, ".sel"}, {5'b0, sel}, {5'b0, es});
        chk({tag, ".valid"}, {7'b0, out_valid}, {7'b0, ev});
        chk({tag, ".ack"}, ack, ea);
        chk({tag, ".busy"}, {7'b0, busy}, {7'b0, eb});
    endtask

    task automatic drive(input logic r, input logic [7:0] rq, input logic [7:0] ls, input logic rdy);
        reset     = r;
        req       = rq;
        last      = ls;
        out_ready = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b1, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
    endtask

    // Reference model: owner index (-1 when idle), last released index, beats taken.
    int         m_owner;
    int         m_ptr;
    int         m_beats;
    logic [2:0] m_sel;

    function automatic int next_winner(input logic [7:0] r, input int from);
        for (int k = 1; k <= 8; k++) begin
            if (r[(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_expect(input logic [7:0] rq, input logic rdy,
                                output logic [7:0] eg, output logic [2:0] es, output logic ev,
                                output logic [7:0] ea, output logic eb);
        eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        es = m_sel;
        eb = (m_owner >= 0);
        ev = (m_owner >= 0) && rq[m_owner];
        ea = (ev && rdy) ? eg : 8'h00;
    endtask

    task automatic model_update(input logic r, input logic [7:0] rq, input logic [7:0] ls,
                                input logic rdy);
        int  w;
        bit  done;
        if (r) begin
            m_owner = -1;
            m_ptr   = 7;
            m_sel   = 3'd0;
            m_beats = 0;
        end else if (m_owner < 0) begin
            w = next_winner(rq, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = 3'(w);
                m_beats = 0;
            end
        end else begin
            done = 1'b0;
            if (!rq[m_owner]) begin
                done = 1'b1;
            end else if (rdy) begin
                m_beats++;
                if (ls[m_owner] || m_beats == int'(BL)) done = 1'b1;
            end
            if (done) begin
                m_ptr = m_owner;
                w = next_winner(rq & ~(8'h01 << m_owner), m_owner);
                if (w >= 0) begin
                    m_owner = w;
                    m_sel   = 3'(w);
                    m_beats = 0;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    initial begin
        logic [7:0] eg;
        logic [2:0] es;
        logic       ev;
        logic [7:0] ea;
        logic       eb;
        logic [7:0] prev_ack;
        logic [7:0] nrq;
        logic [7:0] nls;
        logic       nrst;
        logic       nrdy;

        tbl[0]  = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 8'h01, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 8'h01, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 8'h01, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 8'h08, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
        for (int i = 5; i <= 9; i++)
            tbl[i] = '{1'b0, 8'h08, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 8'h00, 1'b1};
        tbl[10] = '{1'b0, 8'h08, 8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 8'h08, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 8'h00, 1'b0};
        tbl[12] = '{1'b0, 8'h40, 8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 8'h00, 1'b0};
        tbl[13] = '{1'b0, 8'h40, 8'h00, 1'b0, 8'h40, 3'd6, 1'b1, 8'h00, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h40, 3'd6, 1'b0, 8'h00, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 3'd6, 1'b0, 8'h00, 1'b0};
        tbl[16] = '{1'b0, 8'h41, 8'h41, 1'b0, 8'h00, 3'd6, 1'b0, 8'h00, 1'b0};
        tbl[17] = '{1'b0, 8'h41, 8'h41, 1'b0, 8'h01, 3'd0, 1'b1, 8'h00, 1'b1};
        tbl[18] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h01, 3'd0, 1'b0, 8'h00, 1'b1};
        tbl[19] = '{1'b0, 8'h90, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[20] = '{1'b0, 8'h90, 8'h00, 1'b0, 8'h10, 3'd4, 1'b1, 8'h00, 1'b1};

        drive(1'b1, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);

        // Directed vector table: single beat, stalled consumer, abort, ptr after abort.
        for (int i = 0; i < 21; i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].rst, tbl[i].rq, tbl[i].ls, tbl[i].rdy);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].e_gnt, tbl[i].e_sel, tbl[i].e_v,
                    tbl[i].e_ack, tbl[i].e_busy);
        end

        // All requesters with single-beat bursts: back-to-back rotation 0..7,0.
        do_reset();
        drive(1'b0, 8'hFF, 8'hFF, 1'b1);
        #1;
        chk("rot.idle", gnt, 8'h00);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rot%0d.gnt", k), gnt, 8'h01 << (k % 8));
            chk($sformatf("rot%0d.ack", k), ack, 8'h01 << (k % 8));
            chk($sformatf("rot%0d.busy", k), {7'b0, busy}, 8'h01);
        end

        // Endless burst from requester 2 is cut at the beat limit; 5 takes over with no gap.
        do_reset();
        drive(1'b0, 8'h24, 8'h00, 1'b1);
        #1;
        chk("lim.idle", gnt, 8'h00);
        for (int k = 0; k < int'(BL); k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("lim%0d.gnt", k), gnt, 8'h04);
            chk($sformatf("lim%0d.ack", k), ack, 8'h04);
        end
        @(negedge clk);
        #1;
        chk("lim.next.sel", {5'b0, sel}, 8'd5);
        chk("lim.next.gnt", gnt, 8'h20);

        // Reset during beat 3 of requester 4's burst.
        do_reset();
        drive(1'b0, 8'h10, 8'h00, 1'b1);
        #1;
        chk("mid.idle", gnt, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mid%0d.ack", k), ack, 8'h10);
        end
        @(negedge clk);
        drive(1'b1, 8'h10, 8'h00, 1'b1);
        #1;
        chk("mid.rst.gnt", gnt, 8'h10);
        @(negedge clk);
        drive(1'b0, 8'h90, 8'h00, 1'b1);
        #1;
        chk_all("mid.after", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        chk("mid.first.gnt", gnt, 8'h10);
        chk("mid.first.sel", {5'b0, sel}, 8'd4);

        // Randomized traffic against the reference model.
        @(negedge clk);
        drive(1'b1, 8'h00, 8'h00, 1'b0);
        #1;
        model_update(1'b1, 8'h00, 8'h00, 1'b0);
        prev_ack = 8'h00;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            nrst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 8; i++) begin
                if (prev_ack[i])  nrq[i] = $urandom_range(0, 1) == 1;
                else if (req[i])  nrq[i] = $urandom_range(0, 49) != 0;
                else              nrq[i] = $urandom_range(0, 3) == 0;
                nls[i] = (c < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            end
            nrdy = $urandom_range(0, 9) < 7;
            drive(nrst, nrq, nls, nrdy);
            #1;
            model_expect(nrq, nrdy, eg, es, ev, ea, eb);
            chk_all("rnd", eg, es, ev, ea, eb);
            prev_ack = nrst ? 8'h00 : ea;
            model_update(nrst, nrq, nls, nrdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
